// File: rtl/path_follower_pkg.sv
// Shared maze definitions: move codes, FSM state encoding, coordinate width
// and the boundary check used before any coordinate update.
package path_follower_pkg;

  localparam int COORD_W = 4;
  localparam int STEP_W  = 8;

  typedef logic [COORD_W-1:0] coord_t;

  typedef enum logic [1:0] {
    MV_UP    = 2'b00,
    MV_RIGHT = 2'b01,
    MV_LEFT  = 2'b10,
    MV_DOWN  = 2'b11
  } move_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10,
    ST_FAIL = 2'b11
  } state_t;

  typedef struct packed {
    logic  last;
    move_t mv;
  } move_entry_t;

  // True when applying mv at (row, col) stays inside the 16x16 grid.
  function automatic logic move_in_bounds(input move_t mv, input coord_t row, input coord_t col);
    logic ok;
    case (mv)
      MV_UP:    ok = (row != '0);
      MV_DOWN:  ok = (row != '1);
      MV_LEFT:  ok = (col != '0);
      MV_RIGHT: ok = (col != '1);
      default:  ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/path_follower_move_fifo.sv
// Move buffer: DEPTH-entry FIFO of {last, move}. A write is dropped while
// full even if a read happens in the same cycle; clear empties it at once.
module move_fifo
  import path_follower_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_clear,
  input  logic        i_wr,
  input  move_entry_t i_wdata,
  input  logic        i_rd,
  output move_entry_t o_rdata,
  output logic        o_full,
  output logic        o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_count;
  move_entry_t   r_mem [DEPTH];

  logic w_wr;
  logic w_rd;

  assign o_full  = (r_count == (AW+1)'(DEPTH));
  assign o_empty = (r_count == '0);
  assign w_wr    = i_wr && !o_full;
  assign w_rd    = i_rd && !o_empty;
  assign o_rdata = r_mem[r_rptr];

  // Pointer and occupancy tracking; clear has priority over traffic.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else if (i_clear) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_wr) r_wptr <= r_wptr + 1'b1;
      if (w_rd) r_rptr <= r_rptr + 1'b1;
      case ({w_wr, w_rd})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage array needs no reset; occupancy alone defines valid entries.
  always_ff @(posedge clk) begin
    if (w_wr && !i_clear) r_mem[r_wptr] <= i_wdata;
  end

endmodule

// File: rtl/path_follower.sv
// Path follower: buffers grid moves and executes one per cycle, reporting
// each reached position through a valid/ready handshake.
// state | meaning
// IDLE  | after reset, waits for start
// RUN   | accepting and executing moves
// DONE  | last move executed in bounds; outputs held
// FAIL  | a move would have left the grid; outputs held
module path_follower
  import path_follower_pkg::*;
#(
  parameter int     DEPTH    = 4,
  parameter coord_t GOAL_ROW = 4'd15,
  parameter coord_t GOAL_COL = 4'd15
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [1:0]        moveIn,
  input  logic              moveLast,
  input  logic              moveValid,
  output logic              moveReady,
  output coord_t            row,
  output coord_t            col,
  output logic              posValid,
  input  logic              posReady,
  output logic [STEP_W-1:0] stepCount,
  output logic              done,
  output logic              goalHit,
  output logic              fail
);

  state_t            r_state;
  coord_t            r_row;
  coord_t            r_col;
  logic [STEP_W-1:0] r_step;
  logic              r_pos_valid;
  logic              r_done;
  logic              r_goal;
  logic              r_fail;

  logic        w_full;
  logic        w_empty;
  logic        w_wr;
  logic        w_exec;
  logic        w_inb;
  logic        w_fifo_clear;
  move_entry_t w_head;
  move_entry_t w_wentry;
  coord_t      w_nrow;
  coord_t      w_ncol;

  assign moveReady    = (r_state == ST_RUN) && !w_full;
  assign w_wr         = moveValid && moveReady;
  assign w_wentry     = '{last: moveLast, mv: move_t'(moveIn)};
  assign w_exec       = (r_state == ST_RUN) && !w_empty && (!r_pos_valid || posReady) && !start;
  assign w_inb        = move_in_bounds(w_head.mv, r_row, r_col);
  // Leftover moves are dropped once the run ends, whichever way it ends.
  assign w_fifo_clear = start || (w_exec && (w_head.last || !w_inb));

  move_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .i_clear (w_fifo_clear),
    .i_wr    (w_wr),
    .i_wdata (w_wentry),
    .i_rd    (w_exec),
    .o_rdata (w_head),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // Candidate position for the move at the buffer head.
  always_comb begin
    w_nrow = r_row;
    w_ncol = r_col;
    case (w_head.mv)
      MV_UP:    w_nrow = r_row - 1'b1;
      MV_DOWN:  w_nrow = r_row + 1'b1;
      MV_LEFT:  w_ncol = r_col - 1'b1;
      MV_RIGHT: w_ncol = r_col + 1'b1;
      default:  w_nrow = r_row;
    endcase
  end

  // Run control, position/step update and position handshake.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_row       <= '0;
      r_col       <= '0;
      r_step      <= '0;
      r_pos_valid <= 1'b0;
      r_done      <= 1'b0;
      r_goal      <= 1'b0;
      r_fail      <= 1'b0;
    end else if (start) begin
      r_state     <= ST_RUN;
      r_row       <= '0;
      r_col       <= '0;
      r_step      <= '0;
      r_pos_valid <= 1'b0;
      r_done      <= 1'b0;
      r_goal      <= 1'b0;
      r_fail      <= 1'b0;
    end else if (w_exec) begin
      if (w_inb) begin
        r_row       <= w_nrow;
        r_col       <= w_ncol;
        r_pos_valid <= 1'b1;
        r_step      <= (r_step == '1) ? r_step : r_step + 1'b1;
        if (w_head.last) begin
          r_state <= ST_DONE;
          r_done  <= 1'b1;
          r_goal  <= (w_nrow == GOAL_ROW) && (w_ncol == GOAL_COL);
        end
      end else begin
        r_pos_valid <= 1'b0;
        r_fail      <= 1'b1;
        r_state     <= ST_FAIL;
      end
    end else if (r_pos_valid && posReady) begin
      r_pos_valid <= 1'b0;
    end
  end

  assign row       = r_row;
  assign col       = r_col;
  assign posValid  = r_pos_valid;
  assign stepCount = r_step;
  assign done      = r_done;
  assign goalHit   = r_goal;
  assign fail      = r_fail;

endmodule

// File: tb/tb_path_follower.sv
// Scoreboard bench for path_follower: the driver queues the expected
// position of every move it issues, the monitor pops on each handshake.
module tb_path_follower;
  import path_follower_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [1:0] moveIn = 2'b00;
  logic       moveLast = 1'b0;
  logic       moveValid = 1'b0;
  logic       moveReady;
  logic [3:0] row, col;
  logic       posValid;
  logic       posReady = 1'b0;
  logic [7:0] stepCount;
  logic       done, goalHit, fail;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];

  always #5 clk = ~clk;

  path_follower #(.DEPTH(4), .GOAL_ROW(4'd15), .GOAL_COL(4'd15)) dut (
    .clk(clk), .rst(rst), .start(start), .moveIn(moveIn), .moveLast(moveLast),
    .moveValid(moveValid), .moveReady(moveReady), .row(row), .col(col),
    .posValid(posValid), .posReady(posReady), .stepCount(stepCount),
    .done(done), .goalHit(goalHit), .fail(fail)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every position consumed downstream must match the queue head.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      #2;
      if (!rst && posValid && posReady) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_pos: got (%0d,%0d), expected none", row, col);
        end else begin
          e = exp_q.pop_front();
          chk("pos", {row, col}, e);
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic sample();
    @(negedge clk);
    #1;
  endtask

  task automatic do_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic send(input logic [1:0] mv, input logic last);
    int n;
    @(negedge clk);
    moveIn = mv;
    moveLast = last;
    moveValid = 1'b1;
    #1;
    n = 0;
    while (!moveReady && n < 300) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!moveReady) chk("send_accept", moveReady, 1);
    @(posedge clk);
  endtask

  task automatic idle_in();
    @(negedge clk);
    moveValid = 1'b0;
    moveLast = 1'b0;
  endtask

  task automatic wait_end(input string name);
    int n;
    n = 0;
    do begin
      sample();
      n++;
    end while (!(done || fail) && n < 500);
    chk(name, done || fail, 1);
  endtask

  function automatic logic [7:0] rc(input int r, input int c);
    logic [3:0] rr, cc;
    rr = r[3:0];
    cc = c[3:0];
    return {rr, cc};
  endfunction

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_moveReady", moveReady, 0);
    chk("rst_posValid", posValid, 0);
    chk("rst_rowcol", {row, col}, 0);
    chk("rst_step", stepCount, 0);
    chk("rst_flags", {done, goalHit, fail}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) sample();
    chk("idle_moveReady", moveReady, 0);

    // Short path ending at (2,2), not the goal
    posReady = 1'b1;
    do_start();
    exp_q.push_back(rc(0,1)); send(MV_RIGHT, 0);
    exp_q.push_back(rc(0,2)); send(MV_RIGHT, 0);
    exp_q.push_back(rc(1,2)); send(MV_DOWN, 0);
    exp_q.push_back(rc(2,2)); send(MV_DOWN, 1);
    idle_in();
    wait_end("t1_end");
    chk("t1_done", done, 1);
    chk("t1_step", stepCount, 4);
    chk("t1_goal", goalHit, 0);
    chk("t1_fail", fail, 0);
    chk("t1_moveReady", moveReady, 0);
    chk("t1_rowcol", {row, col}, rc(2,2));

    // Up at row 0 fails immediately
    do_start();
    send(MV_UP, 0);
    idle_in();
    wait_end("t2_end");
    chk("t2_fail", fail, 1);
    chk("t2_rowcol", {row, col}, 0);
    chk("t2_posValid", posValid, 0);
    chk("t2_step", stepCount, 0);
    chk("t2_done", done, 0);
    @(negedge clk);
    moveIn = MV_DOWN;
    moveValid = 1'b1;
    repeat (3) sample();
    chk("t2_moveReady", moveReady, 0);
    chk("t2_step_hold", stepCount, 0);
    idle_in();

    // Backpressure: buffer fills, head position held, then drains one per cycle
    @(negedge clk);
    posReady = 1'b0;
    do_start();
    exp_q.push_back(rc(0,1)); send(MV_RIGHT, 0);
    exp_q.push_back(rc(0,2)); send(MV_RIGHT, 0);
    exp_q.push_back(rc(0,3)); send(MV_RIGHT, 0);
    exp_q.push_back(rc(1,3)); send(MV_DOWN, 0);
    exp_q.push_back(rc(2,3)); send(MV_DOWN, 1);
    @(negedge clk);
    moveIn = MV_RIGHT;
    moveLast = 1'b0;
    moveValid = 1'b1;
    #1;
    chk("t3_full_ready", moveReady, 0);
    repeat (3) sample();
    chk("t3_hold_valid", posValid, 1);
    chk("t3_hold_pos", {row, col}, rc(0,1));
    chk("t3_hold_step", stepCount, 1);
    chk("t3_still_full", moveReady, 0);
    @(negedge clk);
    moveValid = 1'b0;
    posReady = 1'b1;
    repeat (3) sample();
    chk("t3_not_done_yet", done, 0);
    chk("t3_step_mid", stepCount, 4);
    sample();
    chk("t3_done", done, 1);
    chk("t3_step", stepCount, 5);
    chk("t3_rowcol", {row, col}, rc(2,3));

    // Full walk to the goal corner
    do_start();
    for (int i = 1; i <= 15; i++) begin
      exp_q.push_back(rc(i, 0));
      send(MV_DOWN, 0);
    end
    for (int j = 1; j <= 15; j++) begin
      exp_q.push_back(rc(15, j));
      send(MV_RIGHT, (j == 15));
    end
    idle_in();
    wait_end("t4_end");
    chk("t4_done", done, 1);
    chk("t4_goal", goalHit, 1);
    chk("t4_step", stepCount, 30);
    chk("t4_rowcol", {row, col}, rc(15,15));
    repeat (2) sample();

    // Restart from DONE
    do_start();
    #1;
    chk("t6_rowcol", {row, col}, 0);
    chk("t6_flags", {done, goalHit}, 0);
    chk("t6_step", stepCount, 0);
    chk("t6_moveReady", moveReady, 1);

    // Sixteenth right at column 15 falls off the grid
    for (int i = 1; i <= 15; i++) begin
      exp_q.push_back(rc(i, 0));
      send(MV_DOWN, 0);
    end
    for (int j = 1; j <= 15; j++) begin
      exp_q.push_back(rc(15, j));
      send(MV_RIGHT, 0);
    end
    send(MV_RIGHT, 0);
    idle_in();
    wait_end("t4b_end");
    chk("t4b_fail", fail, 1);
    chk("t4b_done", done, 0);
    chk("t4b_rowcol", {row, col}, rc(15,15));
    chk("t4b_step", stepCount, 30);
    chk("t4b_posValid", posValid, 0);

    // Reset mid-run with buffered moves
    @(negedge clk);
    posReady = 1'b0;
    do_start();
    send(MV_DOWN, 0);
    send(MV_DOWN, 0);
    send(MV_DOWN, 0);
    send(MV_DOWN, 0);
    idle_in();
    repeat (2) sample();
    chk("t5_pre_step", stepCount, 1);
    chk("t5_pre_valid", posValid, 1);
    @(negedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("t5_rst_moveReady", moveReady, 0);
    chk("t5_rst_posValid", posValid, 0);
    chk("t5_rst_rowcol", {row, col}, 0);
    chk("t5_rst_step", stepCount, 0);
    chk("t5_rst_flags", {done, goalHit, fail}, 0);
    @(negedge clk);
    rst = 1'b0;
    moveIn = MV_DOWN;
    moveValid = 1'b1;
    posReady = 1'b1;
    repeat (3) sample();
    chk("t5_idle_ready", moveReady, 0);
    chk("t5_idle_step", stepCount, 0);
    chk("t5_idle_valid", posValid, 0);
    idle_in();
    do_start();
    exp_q.push_back(rc(1,0));
    send(MV_DOWN, 1);
    idle_in();
    wait_end("t5_end");
    chk("t5_done", done, 1);
    chk("t5_rowcol", {row, col}, rc(1,0));
    chk("t5_step", stepCount, 1);

    repeat (3) sample();
    chk("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
